// File: rtl/encoder_job_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// encoder_job_ctrl : sequences one constant-weight encoding job (load, start,
// collect codewords through an output buffer) and flags job errors. Rev 1.0
// ---------------------------------------------------------------------------
module encoder_job_ctrl #(
  parameter int MSG_BYTES = 8,
  parameter int NUM_CW    = 10,
  parameter int CW_W      = 11,
  parameter int CW_DEPTH  = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            job_go,
  input  logic            err_clr,
  input  logic            host_valid,
  input  logic [7:0]      host_byte,
  output logic            host_ready,
  output logic            enc_rst_b,
  output logic            enc_wr_en,
  output logic [7:0]      enc_msg_byte,
  output logic            enc_start,
  input  logic [CW_W-1:0] enc_cw,
  input  logic            enc_cw_rdy,
  input  logic            enc_cw_done,
  output logic            out_valid,
  output logic [CW_W-1:0] out_cw,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy,
  output logic            job_done,
  output logic [1:0]      err_code
);

  localparam int BC_W  = $clog2(MSG_BYTES + 1);
  localparam int CC_W  = $clog2(NUM_CW + 1);
  localparam int TC_W  = $clog2(TIMEOUT + 1);
  localparam int PTR_W = $clog2(CW_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_OVF   = 2'b01;
  localparam logic [1:0] E_TMO   = 2'b10;
  localparam logic [1:0] E_SHORT = 2'b11;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [1:0]      r_err;
  logic [1:0]      w_err_nxt;
  logic [BC_W-1:0] r_byte_cnt;
  logic [CC_W-1:0] r_cw_cnt;
  logic [CC_W-1:0] w_cw_cnt_nxt;
  logic [TC_W-1:0] r_tmo_cnt;
  logic            r_wr_en;
  logic [7:0]      r_msg_byte;

  logic [PTR_W:0]  r_wr_ptr;
  logic [PTR_W:0]  r_rd_ptr;
  logic [CW_W-1:0] r_mem_cw   [CW_DEPTH];
  logic            r_mem_last [CW_DEPTH];

  logic w_hs;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_ovf;
  logic w_push;
  logic w_tmo_hit;
  logic w_flush;

  assign w_hs       = host_valid && (r_state == S_LOAD);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop      = !w_empty && out_ready;
  assign w_push_req = (r_state == S_RUN) && enc_cw_rdy;
  // A full buffer may still take a word when the head leaves in the same cycle.
  assign w_ovf      = w_push_req && w_full && !w_pop;
  assign w_push     = w_push_req && !w_ovf;
  assign w_cw_cnt_nxt = r_cw_cnt + CC_W'(w_push);
  assign w_tmo_hit  = (r_tmo_cnt == TC_W'(TIMEOUT));
  assign w_flush    = (w_state_nxt == S_ERR);

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE:  if (job_go) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_hs && (r_byte_cnt == BC_W'(MSG_BYTES - 1))) w_state_nxt = S_START;
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_ovf) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = E_OVF;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = E_TMO;
        end else if (enc_cw_done && (w_cw_cnt_nxt != CC_W'(NUM_CW))) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = E_SHORT;
        end else if (w_cw_cnt_nxt == CC_W'(NUM_CW)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR: begin
        if (err_clr) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = E_NONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_err      <= E_NONE;
      r_byte_cnt <= '0;
      r_cw_cnt   <= '0;
      r_tmo_cnt  <= '0;
      r_wr_en    <= 1'b0;
      r_msg_byte <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
      r_wr_en <= w_hs;
      if (w_hs) r_msg_byte <= host_byte;

      if (r_state == S_IDLE) r_byte_cnt <= '0;
      else if (w_hs)         r_byte_cnt <= r_byte_cnt + BC_W'(1);

      if (r_state == S_START) begin
        r_cw_cnt  <= '0;
        r_tmo_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cw_cnt  <= w_cw_cnt_nxt;
        r_tmo_cnt <= w_push ? '0 : r_tmo_cnt + TC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < CW_DEPTH; i++) begin
        r_mem_cw[i]   <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_cw[r_wr_ptr[PTR_W-1:0]]   <= enc_cw;
        r_mem_last[r_wr_ptr[PTR_W-1:0]] <= (w_cw_cnt_nxt == CC_W'(NUM_CW));
        r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  assign host_ready   = (r_state == S_LOAD);
  assign enc_rst_b    = !(rst || (r_state == S_DONE) || (r_state == S_ERR));
  assign enc_wr_en    = r_wr_en;
  assign enc_msg_byte = r_msg_byte;
  assign enc_start    = (r_state == S_START);
  assign out_valid    = !w_empty;
  assign out_cw       = r_mem_cw[r_rd_ptr[PTR_W-1:0]];
  assign out_last     = !w_empty && r_mem_last[r_rd_ptr[PTR_W-1:0]];
  assign busy         = (r_state != S_IDLE);
  assign job_done     = (r_state == S_DONE);
  assign err_code     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_encoder_job_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_encoder_job_ctrl : directed scoreboard bench for encoder_job_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
module tb_encoder_job_ctrl;
  localparam int MSG_BYTES = 8;
  localparam int NUM_CW    = 10;
  localparam int CW_W      = 11;
  localparam int CW_DEPTH  = 4;
  localparam int TIMEOUT   = 4095;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            job_go = 1'b0;
  logic            err_clr = 1'b0;
  logic            host_valid = 1'b0;
  logic [7:0]      host_byte = 8'h00;
  logic            host_ready;
  logic            enc_rst_b;
  logic            enc_wr_en;
  logic [7:0]      enc_msg_byte;
  logic            enc_start;
  logic [CW_W-1:0] enc_cw = '0;
  logic            enc_cw_rdy = 1'b0;
  logic            enc_cw_done = 1'b0;
  logic            out_valid;
  logic [CW_W-1:0] out_cw;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            job_done;
  logic [1:0]      err_code;

  always #5 clk = ~clk;

  encoder_job_ctrl #(
    .MSG_BYTES(MSG_BYTES), .NUM_CW(NUM_CW), .CW_W(CW_W),
    .CW_DEPTH(CW_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .job_go(job_go), .err_clr(err_clr),
    .host_valid(host_valid), .host_byte(host_byte), .host_ready(host_ready),
    .enc_rst_b(enc_rst_b), .enc_wr_en(enc_wr_en), .enc_msg_byte(enc_msg_byte),
    .enc_start(enc_start), .enc_cw(enc_cw), .enc_cw_rdy(enc_cw_rdy),
    .enc_cw_done(enc_cw_done), .out_valid(out_valid), .out_cw(out_cw),
    .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .job_done(job_done), .err_code(err_code)
  );

  int passed = 0;
  int total  = 0;
  logic [7:0]    exp_bytes[$];
  logic [CW_W:0] exp_out[$];
  int n_start = 0;
  int n_done  = 0;
  int n_rstb_low = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Scoreboard monitors: FIFO writes and output-port pops.
  always @(negedge clk) begin
    if (!rst) begin
      if (enc_wr_en) begin
        if (exp_bytes.size() == 0) begin
          total++;
          $display("FAIL wr_unexpected: got byte %0h required no write", enc_msg_byte);
        end else check("wr_byte", {24'h0, enc_msg_byte}, {24'h0, exp_bytes.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          total++;
          $display("FAIL out_unexpected: got cw %0h required no word", out_cw);
        end else check("out_word", {20'h0, out_last, out_cw}, {20'h0, exp_out.pop_front()});
      end
      if (enc_start)  n_start++;
      if (job_done)   n_done++;
      if (!enc_rst_b) n_rstb_low++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_host_ready", host_ready, 0);
    check("rst_wr_en", enc_wr_en, 0);
    check("rst_start", enc_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_job_done", job_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_code, 0);
    check("rst_enc_rst_b", enc_rst_b, 0);
    check("rst_msg_byte", enc_msg_byte, 0);
  endtask

  task automatic start_job(input logic [7:0] base, input bit gaps);
    int k;
    job_go = 1'b1;
    tick();
    job_go = 1'b0;
    for (int i = 0; i < MSG_BYTES; i++) begin
      host_byte  = base + 8'(i);
      host_valid = 1'b1;
      exp_bytes.push_back(host_byte);
      k = 0;
      while (!host_ready && k < 10) begin
        tick();
        k++;
      end
      if (!host_ready) begin
        total++;
        $display("FAIL host_ready_wait: got 0 required 1");
      end
      tick();
      if (gaps && i < MSG_BYTES - 1) begin
        host_valid = 1'b0;
        tick();
        check("ready_held", host_ready, 1);
      end
    end
    host_valid = 1'b0;
    check("enc_start_pulse", enc_start, 1);
    tick();
    check("enc_start_once", enc_start, 0);
  endtask

  task automatic emit(input logic [CW_W-1:0] v);
    enc_cw     = v;
    enc_cw_rdy = 1'b1;
    tick();
    enc_cw_rdy = 1'b0;
  endtask

  task automatic pulse_done();
    enc_cw_done = 1'b1;
    tick();
    enc_cw_done = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!job_done && k < 50) begin
      tick();
      k++;
    end
    check("job_done_seen", job_done, 1);
    tick();
    check("idle_after_done", busy, 0);
    check("enc_rst_b_after_done", enc_rst_b, 1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", err_code, 0);
    check("idle_after_clr", busy, 0);
  endtask

  task automatic full_job(input logic [7:0] bbase, input logic [CW_W-1:0] cbase, input bit gaps);
    int s0, d0, r0;
    s0 = n_start; d0 = n_done; r0 = n_rstb_low;
    out_ready = 1'b1;
    start_job(bbase, gaps);
    for (int i = 0; i < NUM_CW; i++) begin
      exp_out.push_back({(i == NUM_CW - 1), cbase + CW_W'(i)});
      emit(cbase + CW_W'(i));
    end
    pulse_done();
    wait_done();
    check("start_count", n_start - s0, 1);
    check("done_count", n_done - d0, 1);
    check("rstb_low_count", n_rstb_low - r0, 1);
    check("bytes_drained", exp_bytes.size(), 0);
    check("words_drained", exp_out.size(), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();
    check("idle_enc_rst_b", enc_rst_b, 1);
    check("idle_busy", busy, 0);

    // Clean jobs: back-to-back bytes, then bytes with gaps.
    full_job(8'h01, 11'h100, 1'b0);
    full_job(8'hA0, 11'h200, 1'b1);

    // Overflow: fifth word into a full, stalled buffer.
    out_ready = 1'b0;
    start_job(8'h30, 1'b0);
    for (int i = 0; i < CW_DEPTH; i++) emit(11'h300 + CW_W'(i));
    check("ovf_pre_err", err_code, 0);
    check("ovf_head_valid", out_valid, 1);
    check("ovf_head_cw", out_cw, 11'h300);
    check("ovf_head_last", out_last, 0);
    emit(11'h304);
    check("ovf_err", err_code, 1);
    check("ovf_flushed", out_valid, 0);
    check("ovf_host_ready", host_ready, 0);
    check("ovf_enc_rst_b", enc_rst_b, 0);
    check("ovf_busy", busy, 1);
    job_go = 1'b1;
    tick();
    job_go = 1'b0;
    check("err_ignores_go", err_code, 1);
    clear_err();

    // Full buffer with simultaneous push and pop.
    out_ready = 1'b0;
    start_job(8'h40, 1'b0);
    for (int i = 0; i < NUM_CW; i++) exp_out.push_back({(i == NUM_CW - 1), 11'h400 + CW_W'(i)});
    for (int i = 0; i < CW_DEPTH; i++) emit(11'h400 + CW_W'(i));
    out_ready = 1'b1;
    emit(11'h400 + CW_W'(CW_DEPTH));
    out_ready = 1'b0;
    check("pushpop_no_err", err_code, 0);
    check("pushpop_busy", busy, 1);
    out_ready = 1'b1;
    for (int i = CW_DEPTH + 1; i < NUM_CW; i++) emit(11'h400 + CW_W'(i));
    pulse_done();
    wait_done();
    check("pushpop_words_drained", exp_out.size(), 0);

    // Timeout: encoder silent after start.
    out_ready = 1'b1;
    start_job(8'h50, 1'b0);
    k = 0;
    while (err_code == 2'b00 && k < TIMEOUT + 50) begin
      tick();
      k++;
    end
    check("tmo_err", err_code, 2);
    check("tmo_latency", k, TIMEOUT + 1);
    clear_err();

    // Short job: done after 7 codewords.
    out_ready = 1'b1;
    start_job(8'h60, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_out.push_back({1'b0, 11'h600 + CW_W'(i)});
      emit(11'h600 + CW_W'(i));
    end
    pulse_done();
    check("short_err", err_code, 3);
    check("short_words_drained", exp_out.size(), 0);
    clear_err();

    // Reset mid-RUN with words buffered.
    out_ready = 1'b0;
    start_job(8'h70, 1'b0);
    for (int i = 0; i < 3; i++) emit(11'h700 + CW_W'(i));
    check("midrun_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_bytes", exp_bytes.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
